// File: rtl/hazard_forward_unit.sv
// Pipeline hazard detection and forwarding-select unit: tracks in-flight register
// writers and, per source port of the ID instruction, picks a bypass stage or stalls.
module hazard_forward_unit #(
    parameter int ADDR_W     = 5,
    parameter int NSRC       = 2,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic                     id_wr_en,
    input  logic [ADDR_W-1:0]        id_wr_addr,
    input  logic                     id_is_load,
    input  logic [NSRC*ADDR_W-1:0]   id_src_addr,
    input  logic [NSRC-1:0]          id_src_used,
    input  logic                     fwd_en,
    input  logic                     flush,
    output logic                     stall,
    output logic [NSRC*SEL_W-1:0]    fwd_sel,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Tag pipeline, index 1 = EX (youngest), index STAGES = last stage before write-back.
    logic [STAGES:1]   tag_valid;
    logic [STAGES:1]   tag_wr_en;
    logic [STAGES:1]   tag_load;
    logic [ADDR_W-1:0] tag_addr [1:STAGES];

    logic [NSRC-1:0]   port_hit;
    logic [NSRC-1:0]   port_rdy;
    logic [SEL_W-1:0]  port_stage [NSRC];
    logic              match_any;
    logic              wait_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_wr_en <= '0;
            tag_load  <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                tag_addr[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            // A stalled or flushed ID instruction leaves a bubble behind in EX.
            tag_valid[1] <= id_valid & ~stall & ~flush;
            tag_wr_en[1] <= id_wr_en;
            tag_addr[1]  <= id_wr_addr;
            tag_load[1]  <= id_is_load;
            for (int k = 2; k <= STAGES; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_wr_en[k] <= tag_wr_en[k-1];
                tag_addr[k]  <= tag_addr[k-1];
                tag_load[k]  <= tag_load[k-1];
            end
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        port_hit  = '0;
        port_rdy  = '0;
        match_any = 1'b0;
        wait_any  = 1'b0;
        fwd_sel   = '0;
        for (int i = 0; i < NSRC; i++) begin
            port_stage[i] = '0;
            // Scan oldest to youngest so the youngest matching writer wins.
            for (int k = STAGES; k >= 1; k--) begin
                if (tag_valid[k] && tag_wr_en[k] && (tag_addr[k] != '0) &&
                    (tag_addr[k] == id_src_addr[i*ADDR_W +: ADDR_W]) && id_src_used[i]) begin
                    port_hit[i]   = 1'b1;
                    port_stage[i] = SEL_W'(k);
                    port_rdy[i]   = !tag_load[k] || (k >= LOAD_STAGE);
                end
            end
            match_any = match_any | port_hit[i];
            wait_any  = wait_any | (port_hit[i] & ~port_rdy[i]);
            if (fwd_en && port_hit[i] && port_rdy[i]) begin
                fwd_sel[i*SEL_W +: SEL_W] = port_stage[i];
            end
        end
        stall = id_valid && !flush && (fwd_en ? wait_any : match_any);
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (default parameters): each ID cycle pushes
// its expected {stall, fwd_sel} to a queue, popped and compared mid-cycle.
module tb_hazard_forward_unit;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_wr_en;
    logic [4:0]  id_wr_addr;
    logic        id_is_load;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic        fwd_en;
    logic        flush;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt;

    logic [4:0]  exp_q[$];
    int          n_checks;
    int          n_errors;

    hazard_forward_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_wr_en    (id_wr_en),
        .id_wr_addr  (id_wr_addr),
        .id_is_load  (id_is_load),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .fwd_en      (fwd_en),
        .flush       (flush),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one ID cycle; expected values pushed here, compared at the negedge.
    task automatic step(input string tag, input logic v, input logic we, input logic [4:0] wa,
                        input logic ld, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic fl,
                        input logic e_st, input logic [1:0] e0, input logic [1:0] e1);
        logic [4:0] exp;
        id_valid    = v;
        id_wr_en    = we;
        id_wr_addr  = wa;
        id_is_load  = ld;
        id_src_addr = {s1, s0};
        id_src_used = used;
        flush       = fl;
        exp_q.push_back({e_st, e1, e0});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check_val({tag, ".stall"}, {31'd0, stall}, {31'd0, exp[4]});
            check_val({tag, ".fwd_sel"}, {28'd0, fwd_sel}, {28'd0, exp[3:0]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        step("bubble", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        id_valid    = 1'b0;
        id_wr_en    = 1'b0;
        id_wr_addr  = '0;
        id_is_load  = 1'b0;
        id_src_addr = '0;
        id_src_used = '0;
        fwd_en      = 1'b1;
        flush       = 1'b0;
        #2;
        check_val("reset.stall", {31'd0, stall}, 32'd0);
        check_val("reset.fwd_sel", {28'd0, fwd_sel}, 32'd0);
        check_val("reset.cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU write $3 then consume it from each stage in turn
        step("alu_w3", 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("use3_s1", 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 2'd1, 2'd0);
        step("use3_s2", 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 2'd2, 2'd0);
        step("use3_s3", 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 2'd3, 2'd0);
        step("use3_rf", 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 2'd0, 2'd0);
        check_val("cnt_after_alu", {16'd0, stall_cnt}, 32'd0);

        // Load-use on port 1
        step("load_w5", 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("use5_wait", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 2'b10, 1'b0, 1'b1, 2'd0, 2'd0);
        check_val("cnt_load_use", {16'd0, stall_cnt}, 32'd1);
        step("use5_fwd", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 2'b10, 1'b0, 1'b0, 2'd0, 2'd2);

        // $0 never matches
        step("alu_w0", 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("use0", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0);

        // Youngest of two writers to $7 wins on both ports
        step("alu_w7a", 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("alu_w7b", 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("use7x2", 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 2'b11, 1'b0, 1'b0, 2'd1, 2'd1);
        // Unused source port must not match
        step("use7_unused", 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        // Match present but id_valid low: no stall
        step("invalid_id", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);

        // Stall-only mode after a clean reset
        rst = 1'b1;
        #1;
        check_val("rst2.cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        fwd_en = 1'b0;
        step("so_w4", 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        for (int n = 0; n < 3; n++) begin
            step("so_use4_stall", 1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 5'd0, 2'b01, 1'b0, 1'b1, 2'd0, 2'd0);
        end
        step("so_use4_go", 1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 5'd0, 2'b01, 1'b0, 1'b0, 2'd0, 2'd0);
        check_val("so_cnt", {16'd0, stall_cnt}, 32'd3);
        fwd_en = 1'b1;
        bubble();
        bubble();
        bubble();

        // Flushed load-user writing $9 must leave a bubble in EX
        step("load_w6", 1'b1, 1'b1, 5'd6, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("flush_use6", 1'b1, 1'b1, 5'd9, 1'b0, 5'd6, 5'd0, 2'b01, 1'b1, 1'b0, 2'd0, 2'd0);
        check_val("flush_cnt", {16'd0, stall_cnt}, 32'd3);
        step("after_flush", 1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 5'd6, 2'b11, 1'b0, 1'b0, 2'd0, 2'd2);

        // Asynchronous reset with three valid entries in flight
        step("fill_l10", 1'b1, 1'b1, 5'd10, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("fill_a11", 1'b1, 1'b1, 5'd11, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        step("fill_l12", 1'b1, 1'b1, 5'd12, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
        id_valid    = 1'b1;
        id_wr_en    = 1'b0;
        id_is_load  = 1'b0;
        id_src_addr = {5'd11, 5'd12};
        id_src_used = 2'b11;
        flush       = 1'b0;
        #1;
        check_val("pre_rst.stall", {31'd0, stall}, 32'd1);
        check_val("pre_rst.fwd_sel", {28'd0, fwd_sel}, {28'd0, 4'b1000});
        rst = 1'b1;
        #1;
        check_val("async_rst.stall", {31'd0, stall}, 32'd0);
        check_val("async_rst.fwd_sel", {28'd0, fwd_sel}, 32'd0);
        check_val("async_rst.cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b0, 5'd0, 1'b0, 5'd12, 5'd11, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0);
        check_val("post_rst.cnt", {16'd0, stall_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
